// File: rtl/ex_result_buffer.sv
// ex_result_buffer: execute-stage result select into a 2-entry skid buffer with forwarding tap
module ex_result_buffer #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        aluOp,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] shift_out,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  rd,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_result,
  output logic [1:0]        occupancy
);
  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] sd;
    logic [REG_W-1:0]  rd;
    logic              rw;
    logic              mr;
    logic              mw;
  } beat_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_nx;
  beat_t head, skid, cap;
  logic push, pop, ld_head, ld_skid, mv_skid;
  // opcodes 13..15 are the shift group; x0 writes are squashed here so they never forward
  always_comb begin
    cap.res = (aluOp >= 4'hD) ? shift_out : alu_result;
    cap.sd  = store_data;
    cap.rd  = rd;
    cap.rw  = reg_write & (rd != '0);
    cap.mr  = mem_read;
    cap.mw  = mem_write;
  end
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready;
  always_comb begin
    state_nx = state;
    ld_head = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    case (state)
      EMPTY: if (push) begin
        state_nx = ONE;
        ld_head = 1'b1;
      end
      ONE: if (push & pop) ld_head = 1'b1;
        else if (push) begin
          state_nx = TWO;
          ld_skid = 1'b1;
        end else if (pop) state_nx = EMPTY;
      TWO: if (pop) begin
        state_nx = ONE;
        mv_skid = 1'b1;
      end
      default: state_nx = EMPTY;
    endcase
    if (flush) state_nx = EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      skid <= '0;
    end else begin
      head <= ld_head ? cap : mv_skid ? skid : head;
      skid <= ld_skid ? cap : skid;
    end
  assign out_result = head.res;
  assign out_store_data = head.sd;
  assign out_rd = head.rd;
  assign out_reg_write = head.rw;
  assign out_mem_read = head.mr;
  assign out_mem_write = head.mw;
  assign fwd_valid = out_valid & head.rw;
  assign fwd_rd = head.rd;
  assign fwd_result = head.res;
  assign occupancy = state;
endmodule

// File: tb/tb_ex_result_buffer.sv
// tb_ex_result_buffer: scoreboard bench; driver queues expected beats, monitor checks head each cycle
module tb_ex_result_buffer;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
  logic [3:0] aluOp = '0;
  logic [31:0] alu_result = '0, shift_out = '0, store_data = '0;
  logic [4:0] rd = '0;
  logic reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
  logic out_valid, out_ready = 1'b1;
  logic [31:0] out_result, out_store_data, fwd_result;
  logic [4:0] out_rd, fwd_rd;
  logic out_reg_write, out_mem_read, out_mem_write, fwd_valid;
  logic [1:0] occupancy;
  typedef struct packed {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } ex_t;
  ex_t q[$];
  int checks = 0, errors = 0;
  ex_result_buffer #(.DATA_W(32), .REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluOp(aluOp), .alu_result(alu_result), .shift_out(shift_out), .store_data(store_data),
    .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_result(fwd_result), .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: head must match oldest expected beat every valid cycle, popped on handshake
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got res %0h rd %0d with nothing expected", out_result, out_rd);
        end else begin
          chk("head_payload", {out_result, out_store_data},
              {q[0].res, q[0].sd});
          chk("head_ctrl", {out_rd, out_reg_write, out_mem_read, out_mem_write},
              {q[0].rd, q[0].rw, q[0].mr, q[0].mw});
          chk("fwd", {fwd_valid, fwd_rd, fwd_result}, {q[0].rw, q[0].rd, q[0].res});
          if (out_ready) void'(q.pop_front());
        end
      end
      if (flush) q.delete();
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] sh,
                       input logic [31:0] sd, input logic [4:0] r, input logic rw,
                       input logic mr, input logic mw, input logic [31:0] exp_res,
                       input logic exp_rw);
    bit ok = 0;
    in_valid = 1'b1;
    aluOp = op;
    alu_result = alu;
    shift_out = sh;
    store_data = sd;
    rd = r;
    reg_write = rw;
    mem_read = mr;
    mem_write = mw;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        q.push_back('{res: exp_res, sd: sd, rd: r, rw: exp_rw, mr: mr, mw: mw});
        ok = 1;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat rd %0d not accepted within 20 cycles", r);
    end
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask
  initial begin
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_payload", {out_result, out_store_data, out_rd}, 0);
    chk("rst_ctrl", {out_reg_write, out_mem_read, out_mem_write, fwd_valid}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    // result select
    drive(4'hF, 32'h0000_1234, 32'hFFFF_FFF0, 32'h0, 5'd3, 1, 0, 0, 32'hFFFF_FFF0, 1);
    drive(4'h0, 32'h0000_1234, 32'hFFFF_FFF0, 32'h0, 5'd3, 1, 0, 0, 32'h0000_1234, 1);
    drive(4'hD, 32'hAAAA_0000, 32'h0000_5555, 32'h77, 5'd4, 0, 1, 0, 32'h0000_5555, 0);
    drive(4'hC, 32'hAAAA_0000, 32'h0000_5555, 32'h88, 5'd6, 0, 0, 1, 32'hAAAA_0000, 0);
    drive(4'hE, 32'h1111_1111, 32'h2222_2222, 32'h0, 5'd7, 1, 0, 0, 32'h2222_2222, 1);
    idle(3);
    // x0 squash then a normal forwarding write
    drive(4'h1, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1, 0, 0, 32'hDEAD_BEEF, 0);
    drive(4'h1, 32'hCAFE_0005, 32'h0, 32'h0, 5'd5, 1, 0, 0, 32'hCAFE_0005, 1);
    chk("x5_fwd_valid", fwd_valid, 1);
    chk("x5_fwd_rd", fwd_rd, 5);
    idle(3);
    // backpressure: A, B fill the buffer, C waits
    out_ready = 1'b0;
    drive(4'h2, 32'hA, 32'h0, 32'h1, 5'd1, 1, 0, 0, 32'hA, 1);
    drive(4'h2, 32'hB, 32'h0, 32'h2, 5'd2, 1, 0, 0, 32'hB, 1);
    chk("bp_occupancy", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head_A", out_result, 32'hA);
    fork
      drive(4'h2, 32'hC, 32'h0, 32'h3, 5'd3, 1, 0, 0, 32'hC, 1);
      begin
        tick();
        tick();
        chk("bp_C_held_occ", occupancy, 2);
        chk("bp_C_held_head", out_result, 32'hA);
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("bp_drained", occupancy, 0);
    // push and pop together every cycle
    for (int i = 0; i < 8; i++) begin
      drive(4'h3, 32'h100 + i, 32'h0, i, 5'(8 + i), 1, 0, 0, 32'h100 + i, 1);
      chk("sim_occupancy", occupancy, 1);
    end
    idle(3);
    // flush with two held and a beat presented
    out_ready = 1'b0;
    drive(4'h4, 32'h51, 32'h0, 32'h0, 5'd9, 1, 0, 0, 32'h51, 1);
    drive(4'h4, 32'h52, 32'h0, 32'h0, 5'd10, 1, 0, 0, 32'h52, 1);
    aluOp = 4'h4;
    alu_result = 32'h53;
    rd = 5'd11;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_occupancy", occupancy, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_fwd_valid", fwd_valid, 0);
    out_ready = 1'b1;
    drive(4'h5, 32'h60, 32'h0, 32'h0, 5'd12, 1, 0, 0, 32'h60, 1);
    idle(3);
    // async reset mid-stream with two held
    out_ready = 1'b0;
    drive(4'h6, 32'h71, 32'h0, 32'h0, 5'd13, 1, 1, 0, 32'h71, 1);
    drive(4'h6, 32'h72, 32'h0, 32'h0, 5'd14, 1, 0, 1, 32'h72, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_occupancy", occupancy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_payload", {out_result, out_rd, fwd_valid}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    drive(4'hF, 32'h0, 32'h8000_0000, 32'h99, 5'd15, 1, 0, 1, 32'h8000_0000, 1);
    idle(4);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_result_buffer.md
# ex_result_buffer

Execute-stage output buffer for the Mini RISC core. It sits directly downstream of the shift unit and the ALU. Each cycle it selects the execute result (shift result for shift opcodes, ALU result otherwise) and captures it with its writeback/memory control bits into a 2-entry skid buffer with valid/ready handshakes. It also presents the oldest buffered result as a forwarding source.

## Interface
- DATA_W, 32, datapath width
- REG_W, 5, register index width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards all buffered entries
- in_valid  in  1  upstream beat valid
- in_ready  out  1  buffer can accept; decoded from state only, no combinational path from out_ready
- aluOp  in  4  opcode of the incoming beat
- alu_result  in  DATA_W  ALU output
- shift_out  in  DATA_W  shift unit output
- store_data  in  DATA_W  rs2 value for stores
- rd  in  REG_W  destination register
- reg_write, mem_read, mem_write  in  1 each  control bits
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_result, out_store_data  out  DATA_W  head payload
- out_rd  out  REG_W  head destination
- out_reg_write, out_mem_read, out_mem_write  out  1 each  head control
- fwd_valid  out  1  out_valid & out_reg_write
- fwd_rd  out  REG_W  equals out_rd
- fwd_result  out  DATA_W  equals out_result
- occupancy  out  2  entries held (0..2)

## Operation
- Result select at capture: aluOp ∈ {4'b1101, 4'b1110, 4'b1111} → shift_out; any other value → alu_result.
- reg_write is forced to 0 at capture when rd == 0. A write to x0 never forwards or writes back.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready.
- Storage: HEAD register, which drives all out_* signals, and SKID register.
- States: EMPTY (occ 0), ONE (HEAD full), TWO (HEAD and SKID full).
- EMPTY: push → ONE, HEAD ← input.
- ONE:
  - push & pop → ONE, HEAD ← input.
  - push & !pop → TWO, SKID ← input.
  - pop & !push → EMPTY.
  - otherwise hold.
- TWO: in_ready = 0.
  - pop → ONE, HEAD ← SKID.
  - otherwise hold.
- in_ready = (state != TWO).
- Order is strictly FIFO. No beat is duplicated or dropped except by flush.
- flush: next state EMPTY regardless of push/pop.
  - A beat presented in the flush cycle is discarded.
  - A pop in the flush cycle still counts as consumed downstream.
- Payload registers need not be cleared on flush. out_valid and fwd_valid must be 0 the cycle after a flush.

## Timing
- Reset (async assert, sync release): state EMPTY, and all payload registers cleared to 0.
  - Outputs during and after reset: out_valid 0, fwd_valid 0, occupancy 0, in_ready 1.
  - out_result, out_store_data, out_rd and all out_* control bits are 0.
- Reset asserted mid-transfer drops all entries immediately, without waiting for a clock edge.
- Latency: a beat accepted at edge N appears on out_* after edge N (visible in cycle N+1) when the buffer was EMPTY, or ONE with a simultaneous pop.
- Throughput: 1 beat/cycle sustained while out_ready = 1.
- out_* payload is stable while out_valid & !out_ready.
- in_ready deasserts the cycle after the SKID fills, and reasserts the cycle after the first pop from TWO.
- occupancy is registered and matches the state encoding.

## Test plan
- Reset: drive rst_n = 0 mid-stream with 2 entries held → out_valid = 0, occupancy = 0, in_ready = 1, without any clock edge.
- Select: aluOp = 4'b1111, shift_out = 0xFFFF_FFF0, alu_result = 0x1234 → out_result = 0xFFFF_FFF0. Then aluOp = 4'b0000 → out_result = 0x1234.
- Backpressure: out_ready = 0, push A, B, C → A at head, occupancy = 2, in_ready = 0, C not accepted. Raise out_ready → A, B, C delivered in order, one per cycle.
- Simultaneous: in ONE with push & pop every cycle for 8 beats → occupancy stays 1 and outputs appear in input order.
- Flush: occupancy 2, flush = 1 with in_valid = 1 → next cycle occupancy = 0, out_valid = 0, the incoming beat is absent.
- x0: rd = 0, reg_write = 1 → out_reg_write = 0 and fwd_valid = 0. rd = 5 → fwd_valid = 1, fwd_rd = 5.
